multistream_tap_buffer: RTL and testbench

Parametrised multi-stream tap buffer feeding the polyphase FIR datapath. Accepts a time-interleaved sample stream (stream 0..NR_STREAMS-1 cyclic), keeps a NR_TAPS-deep delay line per stream, and emits the full tap window of each stream over a req/ack output port. A per-round shift LUT decides whether a round consumes new input samples or re-emits the held windows for the next interpolation phase.

---
 rtl/mtb_pkg.sv | 31 +++
 rtl/multistream_tap_buffer_if.sv | 47 ++++
 rtl/mtb_round_seq.sv | 55 +++++
 rtl/multistream_tap_buffer.sv | 191 +++++++++++++++++++
 tb/tb_multistream_tap_buffer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtb_pkg.sv
// mtb_pkg: shared definitions for the multi-stream tap buffer.
//   - mtb_state_e : control FSM states
//   - clog2_min1  : ceil(log2(value)), at least 1, for sizing index fields
//   - DEF_*       : default parameter values of the block
package mtb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IN   = 2'd1,
        S_OUT  = 2'd2
    } mtb_state_e;

    localparam int             DEF_DWIDTH         = 16;
    localparam int             DEF_NR_STREAMS     = 16;
    localparam int             DEF_NR_STREAMS_LOG = 4;
    localparam int             DEF_NR_TAPS        = 4;
    localparam int             DEF_L              = 3;
    localparam int             DEF_L_LOG          = 2;
    localparam logic [2:0]     DEF_SHIFT_LUT      = 3'b011;

    // Width needed to index 'value' entries; never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((32'sd1 <<< width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/multistream_tap_buffer_if.sv
// multistream_tap_buffer_if: handshake bundle of the tap buffer.
//   Input side : req_in (buffer ready), ack_in / data_in (producer).
//   Output side: req_out / data_out / stream_out / phase_out (buffer),
//                ack_out (consumer).
//   modport slave  : the tap buffer's view.
//   modport master : the surrounding producer/consumer view.
interface multistream_tap_buffer_if
    import mtb_pkg::*;
#(
    parameter int DWIDTH         = DEF_DWIDTH,
    parameter int NR_TAPS        = DEF_NR_TAPS,
    parameter int NR_STREAMS_LOG = DEF_NR_STREAMS_LOG,
    parameter int L_LOG          = DEF_L_LOG
);

    logic                          req_in;
    logic                          ack_in;
    logic [0:DWIDTH-1]             data_in;
    logic                          req_out;
    logic                          ack_out;
    logic [0:NR_TAPS*DWIDTH-1]     data_out;
    logic [NR_STREAMS_LOG-1:0]     stream_out;
    logic [L_LOG-1:0]              phase_out;

    modport slave (
        output req_in,
        input  ack_in,
        input  data_in,
        output req_out,
        input  ack_out,
        output data_out,
        output stream_out,
        output phase_out
    );

    modport master (
        input  req_in,
        output ack_in,
        output data_in,
        input  req_out,
        output ack_out,
        input  data_out,
        input  stream_out,
        input  phase_out
    );

endinterface

// File: rtl/mtb_round_seq.sv
// mtb_round_seq: stream pointer / round index sequencer.
//   clk, rst : clock, synchronous active-high reset
//   advance  : one window has left the block; step to the next stream
//   sp       : current stream (wraps at NR_STREAMS-1, not by overflow)
//   ri       : current round (wraps at L-1 when sp wraps)
//   shift    : SHIFT_LUT[ri]; 1 = this round consumes input samples
module mtb_round_seq
    import mtb_pkg::*;
#(
    parameter int             NR_STREAMS     = DEF_NR_STREAMS,
    parameter int             NR_STREAMS_LOG = DEF_NR_STREAMS_LOG,
    parameter int             L              = DEF_L,
    parameter int             L_LOG          = DEF_L_LOG,
    parameter logic [L-1:0]   SHIFT_LUT      = DEF_SHIFT_LUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        advance,
    output logic [NR_STREAMS_LOG-1:0]   sp,
    output logic [L_LOG-1:0]            ri,
    output logic                        shift
);

    localparam logic [NR_STREAMS_LOG-1:0] SP_ONE  = NR_STREAMS_LOG'(32'd1);
    localparam logic [NR_STREAMS_LOG-1:0] SP_LAST = NR_STREAMS_LOG'(NR_STREAMS - 1);
    localparam logic [L_LOG-1:0]          RI_ONE  = L_LOG'(32'd1);
    localparam logic [L_LOG-1:0]          RI_LAST = L_LOG'(L - 1);

    logic [NR_STREAMS_LOG-1:0] sp_r;
    logic [L_LOG-1:0]          ri_r;

    // Stream pointer and round index; the round only steps when the stream pointer wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r <= {NR_STREAMS_LOG{1'b0}};
            ri_r <= {L_LOG{1'b0}};
        end else if (advance) begin
            if (sp_r == SP_LAST) begin
                sp_r <= {NR_STREAMS_LOG{1'b0}};
                if (ri_r == RI_LAST) begin
                    ri_r <= {L_LOG{1'b0}};
                end else begin
                    ri_r <= ri_r + RI_ONE;
                end
            end else begin
                sp_r <= sp_r + SP_ONE;
            end
        end
    end

    assign sp    = sp_r;
    assign ri    = ri_r;
    assign shift = SHIFT_LUT[ri_r];

endmodule

// File: rtl/multistream_tap_buffer.sv
// multistream_tap_buffer: per-stream NR_TAPS-deep delay lines over a
// time-interleaved input, emitting each stream's tap window on req/ack.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : run permission; dropping it lets a pending transfer finish
//   bus       : multistream_tap_buffer_if.slave (input and output handshakes)
//   proto_err : only with MTB_PROTOCOL_CHECK_EN; sticky producer misuse flag
// Optional feature macro: MTB_PROTOCOL_CHECK_EN.
module multistream_tap_buffer
    import mtb_pkg::*;
#(
    parameter int             DWIDTH         = DEF_DWIDTH,
    parameter int             NR_STREAMS     = DEF_NR_STREAMS,
    parameter int             NR_STREAMS_LOG = DEF_NR_STREAMS_LOG,
    parameter int             NR_TAPS        = DEF_NR_TAPS,
    parameter int             L              = DEF_L,
    parameter int             L_LOG          = DEF_L_LOG,
    parameter logic [L-1:0]   SHIFT_LUT      = DEF_SHIFT_LUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    multistream_tap_buffer_if.slave   bus
`ifdef MTB_PROTOCOL_CHECK_EN
    ,
    output logic                      proto_err
`endif
);

    mtb_state_e                 state_r;
    mtb_state_e                 state_next_s;
    logic [NR_STREAMS_LOG-1:0]  sp_s;
    logic [L_LOG-1:0]           ri_s;
    logic                       shift_s;
    logic                       req_in_s;
    logic                       req_out_s;
    logic                       in_xfer_s;
    logic                       load_s;
    logic                       out_xfer_s;
    logic [0:NR_TAPS*DWIDTH-1]  win_s;
    logic [0:NR_TAPS*DWIDTH-1]  data_out_r;
    logic [NR_STREAMS_LOG-1:0]  stream_r;
    logic [L_LOG-1:0]           phase_r;
    logic [0:DWIDTH-1]          taps_r [NR_STREAMS][NR_TAPS];

    mtb_round_seq #(
        .NR_STREAMS     (NR_STREAMS),
        .NR_STREAMS_LOG (NR_STREAMS_LOG),
        .L              (L),
        .L_LOG          (L_LOG),
        .SHIFT_LUT      (SHIFT_LUT)
    ) u_round_seq (
        .clk     (clk),
        .rst     (rst),
        .advance (out_xfer_s),
        .sp      (sp_s),
        .ri      (ri_s),
        .shift   (shift_s)
    );

    // A hold round loads its window without waiting for the producer.
    assign in_xfer_s  = (state_r == S_IN) && shift_s && bus.ack_in;
    assign load_s     = in_xfer_s || ((state_r == S_IN) && !shift_s);
    assign out_xfer_s = (state_r == S_OUT) && bus.ack_out;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; enable only gates leaving S_IDLE and re-entering S_IN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_next_s = S_IN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_IN: begin
                if (load_s) begin
                    state_next_s = S_OUT;
                end else begin
                    state_next_s = S_IN;
                end
            end
            S_OUT: begin
                if (bus.ack_out) begin
                    state_next_s = enable ? S_IN : S_IDLE;
                end else begin
                    state_next_s = S_OUT;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // FSM outputs: the two requests are decoded from disjoint states.
    always_comb begin
        req_in_s  = 1'b0;
        req_out_s = 1'b0;
        case (state_r)
            S_IN:    req_in_s  = shift_s;
            S_OUT:   req_out_s = 1'b1;
            default: begin
                req_in_s  = 1'b0;
                req_out_s = 1'b0;
            end
        endcase
    end

    // Window of the current stream: shifted by data_in in a shift round, as held otherwise.
    always_comb begin
        win_s = {(NR_TAPS*DWIDTH){1'b0}};
        win_s[0 +: DWIDTH] = shift_s ? bus.data_in : taps_r[sp_s][0];
        for (int k = 1; k < NR_TAPS; k++) begin
            win_s[k*DWIDTH +: DWIDTH] = shift_s ? taps_r[sp_s][k-1] : taps_r[sp_s][k];
        end
    end

    // Delay lines; only the addressed stream moves, and only on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NR_STREAMS; s++) begin
                for (int k = 0; k < NR_TAPS; k++) begin
                    taps_r[s][k] <= {DWIDTH{1'b0}};
                end
            end
        end else if (in_xfer_s) begin
            for (int k = 0; k < NR_TAPS; k++) begin
                taps_r[sp_s][k] <= win_s[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // Output window registers, held for the whole S_OUT stay.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= {(NR_TAPS*DWIDTH){1'b0}};
            stream_r   <= {NR_STREAMS_LOG{1'b0}};
            phase_r    <= {L_LOG{1'b0}};
        end else if (load_s) begin
            data_out_r <= win_s;
            stream_r   <= sp_s;
            phase_r    <= ri_s;
        end
    end

    assign bus.req_in     = req_in_s;
    assign bus.req_out    = req_out_s;
    assign bus.data_out   = data_out_r;
    assign bus.stream_out = stream_r;
    assign bus.phase_out  = phase_r;

`ifdef MTB_PROTOCOL_CHECK_EN
    logic              proto_err_r;
    logic              wait_in_r;
    logic [0:DWIDTH-1] data_in_q_r;
    logic              stray_ack_s;
    logic              unstable_s;

    // While a request waits, ack_in is low by definition (high would be the
    // transfer itself), so only data_in is watched for stability.
    assign stray_ack_s = bus.ack_in && !req_in_s &&
                         (((state_r == S_IN) && !shift_s) || (state_r == S_OUT));
    assign unstable_s  = wait_in_r && req_in_s && (bus.data_in != data_in_q_r);

    // Sticky misuse flag plus the previous-cycle snapshot it compares against.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_r <= 1'b0;
            wait_in_r   <= 1'b0;
            data_in_q_r <= {DWIDTH{1'b0}};
        end else begin
            wait_in_r   <= req_in_s && !bus.ack_in;
            data_in_q_r <= bus.data_in;
            if (stray_ack_s || unstable_s) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_r;
`endif

endmodule

// File: tb/tb_multistream_tap_buffer.sv
// Self-checking bench for multistream_tap_buffer (3 streams, 4 taps,
// 3 rounds, SHIFT_LUT=3'b101 so round 1 is a hold round). Expected windows
// come from a per-stream delay-line model advanced once per emitted window.
module tb_multistream_tap_buffer;

    localparam int         DW   = 16;
    localparam int         NS   = 3;
    localparam int         NSL  = 2;
    localparam int         NT   = 4;
    localparam int         LL   = 3;
    localparam int         LLOG = 2;
    localparam logic [2:0] LUT  = 3'b101;

    logic clk;
    logic rst;
    logic enable;
    int   vectors;
    int   miscompares;

    multistream_tap_buffer_if #(.DWIDTH(DW), .NR_TAPS(NT), .NR_STREAMS_LOG(NSL), .L_LOG(LLOG)) bus ();

`ifdef MTB_PROTOCOL_CHECK_EN
    logic proto_err;
`endif

    multistream_tap_buffer #(
        .DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NSL), .NR_TAPS(NT),
        .L(LL), .L_LOG(LLOG), .SHIFT_LUT(LUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus.slave)
`ifdef MTB_PROTOCOL_CHECK_EN
        ,
        .proto_err (proto_err)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_taps [NS][NT];
    int m_sp;
    int m_ri;

    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NT; k++)
                m_taps[s][k] = 0;
        m_sp = 0;
        m_ri = 0;
    endfunction

    function automatic bit model_shift();
        logic [2:0] lut_v;
        lut_v = LUT;
        return lut_v[m_ri];
    endfunction

    // Produce the next window the block should emit and advance the model.
    function automatic void model_step(input int d, output logic [63:0] w,
                                       output int st, output int ph, output bit sh);
        sh = model_shift();
        if (sh) begin
            for (int k = NT - 1; k > 0; k--) m_taps[m_sp][k] = m_taps[m_sp][k-1];
            m_taps[m_sp][0] = d & 32'hFFFF;
        end
        for (int k = 0; k < NT; k++) w[k*16 +: 16] = m_taps[m_sp][k][15:0];
        st = m_sp;
        ph = m_ri;
        m_sp = (m_sp + 1) % NS;
        if (m_sp == 0) m_ri = (m_ri + 1) % LL;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic read_win(output logic [63:0] w);
        logic [15:0] t;
        for (int k = 0; k < NT; k++) begin
            t = bus.data_out[k*16 +: 16];
            w[k*16 +: 16] = t;
        end
    endtask

    // Deliver one sample if requested, then wait until req_out is raised.
    task automatic reach_out(input logic [15:0] d, input int in_dly,
                             output bit saw_req_in, output bit to, output int lat);
        int n;
        saw_req_in = 1'b0;
        n = 0;
        while (!bus.req_in && !bus.req_out && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_in) begin
            saw_req_in = 1'b1;
            bus.data_in = d;
            repeat (in_dly) @(negedge clk);
            bus.ack_in = 1'b1;
            @(negedge clk);
            bus.ack_in = 1'b0;
            bus.data_in = 16'($urandom);
        end
        n = 0;
        while (!bus.req_out && n < 20) begin
            if (bus.req_in) saw_req_in = 1'b1;
            @(negedge clk);
            n++;
        end
        to  = !bus.req_out;
        lat = n;
    endtask

    task automatic finish_out(input int out_dly, output logic [63:0] w,
                              output int st, output int ph);
        repeat (out_dly) @(negedge clk);
        read_win(w);
        st = int'(bus.stream_out);
        ph = int'(bus.phase_out);
        bus.ack_out = 1'b1;
        @(negedge clk);
        bus.ack_out = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [63:0] w;
        rst = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        read_win(w);
        vectors += 5;
        if (bus.req_in !== 1'b0)  begin miscompares++; $display("FAIL reset_req_in got %b want 0", bus.req_in); end
        if (bus.req_out !== 1'b0) begin miscompares++; $display("FAIL reset_req_out got %b want 0", bus.req_out); end
        if (w !== 64'd0)          begin miscompares++; $display("FAIL reset_data_out got %h want 0", w); end
        if (bus.stream_out !== 2'd0) begin miscompares++; $display("FAIL reset_stream_out got %0d want 0", bus.stream_out); end
        if (bus.phase_out !== 2'd0)  begin miscompares++; $display("FAIL reset_phase_out got %0d want 0", bus.phase_out); end
        enable = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.req_in !== 1'b0) begin miscompares++; $display("FAIL idle_req_in got %b want 0", bus.req_in); end
        enable = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (bus.req_in !== 1'b1)  begin miscompares++; $display("FAIL enable_req_in got %b want 1", bus.req_in); end
        if (bus.req_out !== 1'b0) begin miscompares++; $display("FAIL enable_req_out got %b want 0", bus.req_out); end
    endtask

    task automatic test_stream(input int count);
        logic [63:0] w, ew;
        int st, est, ph, eph, lat;
        bit sh, saw, to;
        logic [15:0] d;
        for (int i = 0; i < count; i++) begin
            d = 16'($urandom);
            model_step(int'(d), ew, est, eph, sh);
            reach_out(d, $urandom_range(0, 2), saw, to, lat);
            vectors += 3;
            if (to !== 1'b0)  begin miscompares++; $display("FAIL stream_timeout win %0d", i); end
            if (saw !== sh)   begin miscompares++; $display("FAIL stream_req_in_round win %0d got %b want %b", i, saw, sh); end
            if (lat !== 0)    begin miscompares++; $display("FAIL stream_out_latency win %0d got %0d want 0", i, lat); end
            finish_out($urandom_range(0, 2), w, st, ph);
            vectors += 4;
            if (w !== ew)     begin miscompares++; $display("FAIL stream_window win %0d got %h want %h", i, w, ew); end
            if (st !== est)   begin miscompares++; $display("FAIL stream_id win %0d got %0d want %0d", i, st, est); end
            if (ph !== eph)   begin miscompares++; $display("FAIL stream_phase win %0d got %0d want %0d", i, ph, eph); end
            if (bus.req_in !== model_shift()) begin
                miscompares++;
                $display("FAIL back_to_back_req_in win %0d got %b want %b", i, bus.req_in, model_shift());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, ew, w;
        int st, est, ph, eph, lat;
        bit sh, saw, to;
        logic [15:0] d;
        d = 16'($urandom);
        model_step(int'(d), ew, est, eph, sh);
        reach_out(d, 0, saw, to, lat);
        read_win(a);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            read_win(b);
            vectors += 4;
            if (b !== a)             begin miscompares++; $display("FAIL stall_data cycle %0d got %h want %h", c, b, a); end
            if (bus.req_out !== 1'b1) begin miscompares++; $display("FAIL stall_req_out cycle %0d got %b want 1", c, bus.req_out); end
            if (bus.req_in !== 1'b0)  begin miscompares++; $display("FAIL stall_req_in cycle %0d got %b want 0", c, bus.req_in); end
            if (int'(bus.stream_out) !== est) begin miscompares++; $display("FAIL stall_stream cycle %0d got %0d want %0d", c, bus.stream_out, est); end
        end
        finish_out(0, w, st, ph);
        vectors++;
        if (w !== ew) begin miscompares++; $display("FAIL stall_window got %h want %h", w, ew); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] w, ew;
        int st, est, ph, eph, lat;
        bit sh, saw, to;
        model_step(int'(16'h1234), ew, est, eph, sh);
        reach_out(16'h1234, 0, saw, to, lat);
        rst = 1'b1;
        @(negedge clk);
        read_win(w);
        vectors += 4;
        if (bus.req_out !== 1'b0)     begin miscompares++; $display("FAIL midrst_req_out got %b want 0", bus.req_out); end
        if (bus.req_in !== 1'b0)      begin miscompares++; $display("FAIL midrst_req_in got %b want 0", bus.req_in); end
        if (w !== 64'd0)              begin miscompares++; $display("FAIL midrst_data_out got %h want 0", w); end
        if (bus.stream_out !== 2'd0)  begin miscompares++; $display("FAIL midrst_stream got %0d want 0", bus.stream_out); end
        rst = 1'b0;
        model_reset();
        model_step(9, ew, est, eph, sh);
        reach_out(16'd9, 1, saw, to, lat);
        finish_out(0, w, st, ph);
        vectors += 3;
        if (w !== 64'h0000_0000_0000_0009) begin miscompares++; $display("FAIL after_rst_window got %h want 0000000000000009", w); end
        if (w !== ew)  begin miscompares++; $display("FAIL after_rst_model got %h want %h", w, ew); end
        if (st !== 0 || ph !== 0) begin miscompares++; $display("FAIL after_rst_id got s%0d/p%0d want s0/p0", st, ph); end
    endtask

    task automatic test_enable_drop();
        logic [63:0] w, ew;
        int st, est, ph, eph, lat;
        bit sh, saw, to;
        logic [15:0] d;
        d = 16'($urandom);
        model_step(int'(d), ew, est, eph, sh);
        reach_out(d, 0, saw, to, lat);
        enable = 1'b0;
        finish_out(1, w, st, ph);
        vectors++;
        if (w !== ew) begin miscompares++; $display("FAIL endrop_window got %h want %h", w, ew); end
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (bus.req_in !== 1'b0 || bus.req_out !== 1'b0) begin
                miscompares++;
                $display("FAIL endrop_idle cycle %0d got req_in=%b req_out=%b want 0/0", c, bus.req_in, bus.req_out);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        d = 16'($urandom);
        model_step(int'(d), ew, est, eph, sh);
        reach_out(d, 0, saw, to, lat);
        finish_out(0, w, st, ph);
        vectors += 3;
        if (to !== 1'b0) begin miscompares++; $display("FAIL endrop_resume_timeout"); end
        if (st !== est)  begin miscompares++; $display("FAIL endrop_resume_stream got %0d want %0d", st, est); end
        if (w !== ew)    begin miscompares++; $display("FAIL endrop_resume_window got %h want %h", w, ew); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        bus.ack_in = 1'b0;
        bus.ack_out = 1'b0;
        bus.data_in = 16'h0000;
        vectors = 0;
        miscompares = 0;
        @(negedge clk);
        test_reset();
        test_stream(30);
        test_backpressure();
        test_reset_mid();
        test_enable_drop();
        test_stream(12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
